// File: rtl/pkt_ctrl_fsm.sv
// pkt_ctrl_fsm: header/payload/trailer phase controller with payload limit and per-frame done/error pulses.
// Define PKT_TIMEOUT_EN to build the trailer watchdog (TIMEOUT_CYC cycles without term aborts the frame).
module pkt_ctrl_fsm #(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] TERM_SYM    = '0,
    parameter int                MAX_PAYLOAD = 1500,
    parameter int                CNT_W       = 11,
    parameter int                TIMEOUT_CYC = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              control,
    input  logic [DATA_W-1:0] data,
    input  logic              type_length_valid,
    input  logic              packet_size_valid,
    output logic              enable_header,
    output logic              enable_payload,
    output logic [CNT_W-1:0]  payload_count,
    output logic              frame_done,
    output logic              frame_error
);
    typedef enum logic [1:0] {HDR = 2'b00, PAY = 2'b01, TRL = 2'b10, ERR = 2'b11} state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PAYLOAD);

    if (MAX_PAYLOAD < 2 || (1 << CNT_W) <= MAX_PAYLOAD || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("pkt_ctrl_fsm: illegal parameter combination");
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt_n, cnt_inc;
    logic             done_n, err_n, term, tmo;

    assign term    = !control && data == TERM_SYM;
    assign cnt_inc = payload_count + 1'b1;

`ifdef PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] trl_cnt;

    // counts edges spent in TRL; zero on the entry edge
    always_ff @(posedge clock) begin
        if (reset)
            trl_cnt <= '0;
        else
            trl_cnt <= (state == TRL && state_n == TRL) ? trl_cnt + 1'b1 : '0;
    end

    assign tmo = trl_cnt == TW'(TIMEOUT_CYC - 1);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = payload_count;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            HDR: begin
                if (control && type_length_valid) begin
                    state_n = PAY;
                    cnt_n   = '0;
                end
            end
            PAY: begin
                cnt_n = cnt_inc;
                if (packet_size_valid) begin
                    state_n = TRL;
                end else if (cnt_inc == MAX_C) begin
                    state_n = ERR;
                    err_n   = 1'b1;
                end
            end
            TRL: begin
                if (term) begin
                    state_n = HDR;
                    done_n  = 1'b1;
                end else if (tmo) begin
                    state_n = ERR;
                    err_n   = 1'b1;
                end
            end
            ERR: state_n = term ? HDR : ERR;
            default: state_n = HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= HDR;
            enable_header  <= 1'b1;
            enable_payload <= 1'b0;
            payload_count  <= '0;
            frame_done     <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            state          <= state_n;
            enable_header  <= state_n == HDR;
            enable_payload <= state_n == PAY;
            payload_count  <= cnt_n;
            frame_done     <= done_n;
            frame_error    <= err_n;
        end
    end
endmodule

// File: doc/pkt_ctrl_fsm.md
# pkt_ctrl_fsm

Parametrised controller for the Ethernet packet detector. It steers the header and payload modules through header, payload and trailer phases of each frame. It counts payload cycles, rejects frames that exceed a configurable payload limit, and reports per-frame completion and error pulses. It sits between the input symbol stream and the header/payload enable consumers, replacing the fixed 8-bit, three-state controller.

## Interface
Parameters:
- DATA_W, 8, width of the data symbol bus
- TERM_SYM, 0 (DATA_W bits), data value that marks end of frame when control is low
- MAX_PAYLOAD, 1500, maximum legal payload length in cycles; must be ≥ 2
- CNT_W, 11, payload counter width; must satisfy 2^CNT_W > MAX_PAYLOAD
- TIMEOUT_CYC, 64, trailer watchdog limit in cycles (used only with PKT_TIMEOUT_EN)

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- control  in  1  control/data qualifier for the current symbol
- data  in  DATA_W  current stream symbol
- type_length_valid  in  1  header checker reports a valid type/length field
- packet_size_valid  in  1  payload checker reports that the expected size has been reached
- enable_header  out  1  enables the header module
- enable_payload  out  1  enables the payload module
- payload_count  out  CNT_W  payload cycles counted for the current or last frame
- frame_done  out  1  one-cycle pulse on clean end of frame
- frame_error  out  1  one-cycle pulse on frame abort

## Operation
- States: HDR (2'b00), PAY (2'b01), TRL (2'b10), ERR (2'b11). Any unreachable encoding returns to HDR on the next edge.
- Reset values: state=HDR, enable_header=1, enable_payload=0, payload_count=0, frame_done=0, frame_error=0. Reset overrides all other inputs, including mid-frame.
- term = (control==0 && data==TERM_SYM).
- HDR: if control && type_length_valid, go to PAY and set payload_count=0. Otherwise stay in HDR.
- PAY: payload_count increments by 1 on every edge spent in PAY, including the exit edge.
  - If packet_size_valid is high, go to TRL.
  - Else if payload_count+1 == MAX_PAYLOAD, go to ERR and pulse frame_error.
  - packet_size_valid has priority over the limit check on the same edge.
- TRL: on term, go to HDR and pulse frame_done. payload_count holds.
- ERR: on term, go to HDR. No frame_done pulse. payload_count holds.
- Output decode from the next state, all registered:
  - enable_header = (HDR)
  - enable_payload = (PAY)
  - TRL and ERR drive both enables low.
- payload_count holds after frame end until the next HDR→PAY transition. It never wraps.
- Simultaneous events:
  - type_length_valid without control is ignored.
  - term seen while in PAY is ignored.

## Timing
- All outputs are registered. Inputs sampled at edge N are reflected on the outputs after edge N, so state-change latency is one cycle.
- frame_done and frame_error are exactly one cycle wide, asserted in the cycle after the deciding edge, and never both high.
- Minimum frame is 3 cycles: HDR→PAY, PAY→TRL with count=1, TRL→HDR.
- Back-to-back frames: after TRL→HDR, a new header may be accepted on the very next edge.

## Configuration
- PKT_TIMEOUT_EN defined:
  - A trailer counter clears on entry to TRL and increments each cycle in TRL.
  - If TIMEOUT_CYC cycles elapse without term, go to ERR and pulse frame_error.
  - term on the same edge as timeout wins and goes to HDR with frame_done.
- PKT_TIMEOUT_EN undefined: TRL waits indefinitely for term. The TIMEOUT_CYC parameter is ignored and no watchdog logic is built.

## Test plan
- Reset, then control=1 + type_length_valid=1 → next cycle enable_header=0, enable_payload=1. After 4 PAY cycles, assert packet_size_valid → payload_count=5, both enables 0. Then control=0, data=0x00 → enable_header=1 and a frame_done pulse of one cycle.
- MAX_PAYLOAD=8, never assert packet_size_valid → after 8 PAY cycles: frame_error pulse, state ERR, payload_count=8. A term symbol then returns to HDR with no frame_done.
- MAX_PAYLOAD=8, assert packet_size_valid on the 8th PAY cycle → TRL and no frame_error (priority check).
- Assert reset mid-PAY with count=3 → next cycle enable_header=1, enable_payload=0, payload_count=0, no pulses.
- With PKT_TIMEOUT_EN and TIMEOUT_CYC=4, hold data=0x55 in TRL → frame_error after 4 cycles. Repeat with term on the 4th cycle → frame_done instead.
- DATA_W=16, TERM_SYM=16'hFFFF: control=0, data=0x0000 in TRL → stays in TRL; data=0xFFFF → HDR.
